uart_text_bus_top: RTL and testbench

- Serial text-command front end with an internal byte register file.
- Receives ASCII commands over an 8N1 UART at 115200 baud from a 40 MHz clock, parses write/read commands, writes to or reads from the register file, and sends read results back as ASCII hex.
- Top-level block of the UART bench design, with its pins connected directly to the serial line.

---
 rtl/uart_text_pkg.sv | 36 +++
 rtl/uart_txrx.sv | 123 ++++++++++++
 rtl/uart_text_bus_top.sv | 135 +++++++++++++
 tb/tb_uart_text_bus_top.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_text_pkg.sv
// Shared constants, parser state type and ASCII helpers for the UART text bus.
package uart_text_pkg;

   localparam logic [7:0] CH_CR  = 8'h0d;
   localparam logic [7:0] CH_LF  = 8'h0a;
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_TAB = 8'h09;
   localparam logic [7:0] CH_W   = 8'h77;
   localparam logic [7:0] CH_WU  = 8'h57;
   localparam logic [7:0] CH_R   = 8'h72;
   localparam logic [7:0] CH_RU  = 8'h52;

   typedef enum logic [2:0] {
      P_IDLE, P_CMD, P_SEP1, P_DATA, P_SEP2, P_ADDR, P_REPLY, P_ERR
   } pstate_e;

   // Clock cycles per serial bit, rounded to nearest.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   // Letters share the low nibble pattern 1..6 for a..f and A..F.
   function automatic logic [3:0] asc2nib(input logic [7:0] c);
      return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
   endfunction

   function automatic logic [7:0] nib2asc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_txrx.sv
// 8N1 UART receive and transmit engines sharing one bit period setting.
module uart_txrx #(
   parameter int CPB = 347
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o
);
   localparam int CW   = $clog2(CPB + 1);
   localparam int HALF = CPB / 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   logic [1:0]    sync_q;
   logic          prev_q, line;
   rx_state_e     rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_vld_q, rx_vld_d;

   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [9:0]    tx_sh_q, tx_sh_d;
   logic          frame_end;

   assign line       = sync_q[1];
   assign rx_valid_o = rx_vld_q;
   assign rx_data_o  = rx_sh_q;
   assign frame_end  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CW'(CPB - 1));
   assign tx_ready_o = !tx_busy_q || frame_end;
   assign tx_o       = tx_busy_q ? tx_sh_q[0] : 1'b1;

   // Receiver: edge detect, half-bit start confirm, mid-bit sampling, stop check.
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + CW'(1);
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_vld_d = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (prev_q && !line) rx_st_d = RX_START;
         end
         RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = line ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == CW'(CPB - 1)) begin
            rx_cnt_d = '0;
            rx_sh_d  = {line, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
         end
         default: if (rx_cnt_q == CW'(CPB - 1)) begin
            rx_st_d  = RX_IDLE;
            rx_vld_d = line;
         end
      endcase
   end

   // Transmitter: shift a 10-bit frame; a new frame may load on the last stop cycle.
   always_comb begin
      tx_busy_d = tx_busy_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      if (tx_busy_q) begin
         tx_cnt_d = tx_cnt_q + CW'(1);
         if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
         end
      end
      if (tx_start_i && tx_ready_o) begin
         tx_busy_d = 1'b1;
         tx_cnt_d  = '0;
         tx_bit_d  = '0;
         tx_sh_d   = {1'b1, tx_data_i, 1'b0};
      end
   end

   // State registers for both engines and the input synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         prev_q    <= 1'b1;
         rx_st_q   <= RX_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_vld_q  <= 1'b0;
         tx_busy_q <= 1'b0;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '1;
      end else begin
         sync_q    <= {sync_q[0], rx_i};
         prev_q    <= line;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         rx_vld_q  <= rx_vld_d;
         tx_busy_q <= tx_busy_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
      end
   end

endmodule

// File: rtl/uart_text_bus_top.sv
// Text command parser and byte register file behind a UART.
module uart_text_bus_top #(
   parameter int CLK_HZ = 40000000,
   parameter int BAUD   = 115200,
   parameter int AW     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ser_in,
   output logic ser_out
);
   import uart_text_pkg::*;

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

   logic          rx_valid, tx_start, tx_ready;
   logic [7:0]    rx_data, tx_data;
   logic          is_sep, is_cr, hex;
   logic [3:0]    nib;

   pstate_e       st_q, st_d;
   logic          wr_q, wr_d, we_q, we_d;
   logic [7:0]    data_q, data_d, rep_byte_q, rep_byte_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [2:0]    rep_cnt_q, rep_cnt_d;
   logic [7:0]    mem_q [2**AW];

   uart_txrx #(.CPB(CPB)) u_txrx (
      .clk(clk), .rst_n(rst), .rx_i(ser_in), .tx_o(ser_out),
      .rx_valid_o(rx_valid), .rx_data_o(rx_data),
      .tx_start_i(tx_start), .tx_data_i(tx_data), .tx_ready_o(tx_ready)
   );

   assign is_sep   = (rx_data == CH_SP) || (rx_data == CH_TAB);
   assign is_cr    = (rx_data == CH_CR);
   assign hex      = is_hex(rx_data);
   assign nib      = asc2nib(rx_data);
   assign tx_start = (rep_cnt_q != 3'd0);

   // Reply byte selection: hex high, hex low, CR, LF.
   always_comb begin
      case (rep_cnt_q)
         3'd4:    tx_data = nib2asc(rep_byte_q[7:4]);
         3'd3:    tx_data = nib2asc(rep_byte_q[3:0]);
         3'd2:    tx_data = CH_CR;
         default: tx_data = CH_LF;
      endcase
   end

   // Parser next state; REPLY waits only while a previous reply is still queued.
   always_comb begin
      st_d       = st_q;
      wr_d       = wr_q;
      data_d     = data_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
      rep_cnt_d  = rep_cnt_q;
      rep_byte_d = rep_byte_q;
      if (tx_start && tx_ready) rep_cnt_d = rep_cnt_q - 3'd1;
      if (st_q == P_REPLY) begin
         if (rep_cnt_q == 3'd0) begin
            rep_byte_d = mem_q[addr_q];
            rep_cnt_d  = 3'd4;
            st_d       = P_IDLE;
         end
      end else if (rx_valid) begin
         case (st_q)
            P_IDLE:
               if (rx_data == CH_W || rx_data == CH_WU) begin
                  wr_d = 1'b1; st_d = P_CMD;
               end else if (rx_data == CH_R || rx_data == CH_RU) begin
                  wr_d = 1'b0; st_d = P_CMD;
               end else if (!is_cr && rx_data != CH_LF) st_d = P_ERR;
            P_CMD:
               if (is_sep) st_d = P_SEP1;
               else st_d = is_cr ? P_IDLE : P_ERR;
            P_SEP1:
               if (is_sep) st_d = P_SEP1;
               else if (hex && wr_q) begin
                  data_d = {4'h0, nib}; st_d = P_DATA;
               end else if (hex) begin
                  addr_d = AW'(nib); st_d = P_ADDR;
               end else st_d = is_cr ? P_IDLE : P_ERR;
            P_DATA:
               if (hex) data_d = {data_q[3:0], nib};
               else if (is_sep) st_d = P_SEP2;
               else st_d = is_cr ? P_IDLE : P_ERR;
            P_SEP2:
               if (is_sep) st_d = P_SEP2;
               else if (hex) begin
                  addr_d = AW'(nib); st_d = P_ADDR;
               end else st_d = is_cr ? P_IDLE : P_ERR;
            P_ADDR:
               if (hex) addr_d = AW'({addr_q, nib});
               else if (is_cr && wr_q) begin
                  we_d = 1'b1; st_d = P_IDLE;
               end else st_d = is_cr ? P_REPLY : P_ERR;
            P_ERR:
               if (is_cr) st_d = P_IDLE;
            default: st_d = P_IDLE;
         endcase
      end
   end

   // Parser and reply registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= P_IDLE;
         wr_q       <= 1'b0;
         we_q       <= 1'b0;
         data_q     <= '0;
         addr_q     <= '0;
         rep_cnt_q  <= '0;
         rep_byte_q <= '0;
      end else begin
         st_q       <= st_d;
         wr_q       <= wr_d;
         we_q       <= we_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         rep_cnt_q  <= rep_cnt_d;
         rep_byte_q <= rep_byte_d;
      end
   end

   // Register file, written one cycle after a write command's CR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2**AW; i++) mem_q[i] <= 8'h00;
      end else if (we_q) begin
         mem_q[addr_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_uart_text_bus_top.sv
// Directed bench: serial stimulus in, serial replies checked against a byte scoreboard.
module tb_uart_text_bus_top;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ser_in = 1'b1;
   logic ser_out;

   int checks = 0;
   int errors = 0;
   int exp_total = 0;
   int mon_cnt = 0;
   logic mon_abort = 1'b0;
   logic [7:0] exp_q[$];

   uart_text_bus_top #(.CLK_HZ(1600000), .BAUD(100000), .AW(8)) dut (
      .clk(clk), .rst(rst), .ser_in(ser_in), .ser_out(ser_out)
   );

   always #12.5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mon_wait(input int n);
      repeat (n) begin
         @(negedge clk);
         if (!rst) mon_abort = 1'b1;
      end
   endtask

   // Serial-line monitor: decodes each frame on ser_out and pops the scoreboard.
   initial begin : monitor
      logic [7:0] b;
      logic stp;
      forever begin
         @(negedge clk);
         if (rst && ser_out === 1'b0) begin
            mon_abort = 1'b0;
            mon_wait(CPB / 2);
            for (int i = 0; i < 8; i++) begin
               mon_wait(CPB);
               b[i] = ser_out;
            end
            mon_wait(CPB);
            stp = ser_out;
            if (!mon_abort) begin
               mon_cnt++;
               checks++;
               assert (exp_q.size() != 0) else begin
                  errors++;
                  $error("FAIL unexpected_tx: observed %h expected no byte", b);
               end
               if (exp_q.size() != 0) chk("tx_byte", {7'h0, stp, b}, {8'h01, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      ser_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ser_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      ser_in = stop;
      repeat (CPB) @(negedge clk);
      ser_in = 1'b1;
   endtask

   task automatic send_line(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
      send_byte(8'h0d, 1'b1);
   endtask

   task automatic push_exp(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
      exp_total += s.len() + 2;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 16'(exp_q.size()), 16'd0);
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin : stimulus
      int n;
      repeat (5) @(negedge clk);
      chk("reset_ser_out", {15'h0, ser_out}, 16'h0001);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_mem0", {8'h0, dut.mem_q[0]}, 16'h0000);

      // Writes produce no output.
      send_line("w 01 0000");
      send_line("w 16 0001");
      repeat (4 * CPB) @(negedge clk);
      chk("no_reply_after_write", 16'(mon_cnt), 16'd0);
      chk("mem0_written", {8'h0, dut.mem_q[0]}, 16'h0001);
      chk("mem1_written", {8'h0, dut.mem_q[1]}, 16'h0016);

      // Reads.
      push_exp("01");
      send_line("r 0");
      wait_drain("read0");
      push_exp("16");
      send_line("r 1");
      wait_drain("read1");
      push_exp("00");
      send_line("r 1a");
      wait_drain("read1a_empty");
      send_line("w ff 1a");
      push_exp("ff");
      send_line("r 001A");
      wait_drain("read1a_ff");
      chk("mem1a_written", {8'h0, dut.mem_q[8'h1a]}, 16'h00ff);

      // Malformed lines, then a good read.
      send_line("x 12");
      send_line("w 5 ");
      push_exp("01");
      send_line("r 0");
      wait_drain("read_after_errors");
      chk("mem0_unchanged", {8'h0, dut.mem_q[0]}, 16'h0001);
      chk("mem5_unchanged", {8'h0, dut.mem_q[5]}, 16'h0000);

      // Start glitch and framing error inside a read line must not disturb it.
      push_exp("16");
      send_byte("r", 1'b1);
      send_byte(" ", 1'b1);
      @(negedge clk);
      ser_in = 1'b0;
      repeat (4) @(negedge clk);
      ser_in = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_byte("x", 1'b0);
      repeat (2 * CPB) @(negedge clk);
      send_byte("1", 1'b1);
      send_byte(8'h0d, 1'b1);
      wait_drain("read_with_glitch_and_frame_err");

      // Reset in the middle of receiving a write.
      send_byte("w", 1'b1);
      send_byte(" ", 1'b1);
      send_byte("2", 1'b1);
      send_byte("2", 1'b1);
      send_byte(" ", 1'b1);
      send_byte("0", 1'b1);
      @(negedge clk);
      ser_in = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ser_out_in_rx_reset", {15'h0, ser_out}, 16'h0001);
      ser_in = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("mem0_cleared_rx_reset", {8'h0, dut.mem_q[0]}, 16'h0000);
      chk("mem1_cleared_rx_reset", {8'h0, dut.mem_q[1]}, 16'h0000);

      // Reset while a reply is on the line.
      send_line("w 5a 0");
      send_line("r 0");
      n = 0;
      while (ser_out !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reply_started", 16'(n < 500), 16'd1);
      repeat (2 * CPB + 3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ser_out_in_reply_reset", {15'h0, ser_out}, 16'h0001);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      chk("mem0_cleared_reply_reset", {8'h0, dut.mem_q[0]}, 16'h0000);
      push_exp("00");
      send_line("r 0");
      wait_drain("read_after_reset");

      repeat (10 * CPB) @(negedge clk);
      chk("tx_byte_total", 16'(mon_cnt), 16'(exp_total));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
